// File: rtl/flit_fifo.sv
// Flit FIFO: circular buffer with first-word-fall-through head, flit type
// decode, complete-packet tracking and sticky overflow/underflow flags.
module flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            flit_id,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_WIDTH:0]    count,
    output logic                  pkt_avail,
    output logic                  ovf,
    output logic                  udf
);

    localparam logic [2:0]         TYPE_TAIL = 3'b100;
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = DEPTH[PTR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic [PTR_WIDTH:0]   tail_cnt_q, tail_cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic                 wr_acc, rd_acc;
    logic                 tail_in, tail_out;
    logic [2:0]           head_type;

    // Status is a pure function of the registered count, so it follows
    // reset asynchronously along with the counters.
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign count     = count_q;
    assign pkt_avail = (tail_cnt_q != '0);
    assign ovf       = ovf_q;
    assign udf       = udf_q;

    assign dout      = mem[rd_ptr_q];
    assign head_type = dout[DATA_WIDTH-1:DATA_WIDTH-3];
    assign flit_id   = empty ? 3'b000 : head_type;

    // A simultaneous pop frees the slot being written, so full does not block.
    assign wr_acc   = wr_en && (!full || rd_en);
    assign rd_acc   = rd_en && !empty;
    assign tail_in  = wr_acc && (din[DATA_WIDTH-1:DATA_WIDTH-3] == TYPE_TAIL);
    assign tail_out = rd_acc && (head_type == TYPE_TAIL);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tail_cnt_d = tail_cnt_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case ({tail_in, tail_out})
            2'b10:   tail_cnt_d = tail_cnt_q + 1'b1;
            2'b01:   tail_cnt_d = tail_cnt_q - 1'b1;
            default: tail_cnt_d = tail_cnt_q;
        endcase

        if (wr_en && full && !rd_en) ovf_d = 1'b1;
        if (rd_en && empty)          udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tail_cnt_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tail_cnt_q <= tail_cnt_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= din;
    end

endmodule

// File: tb/tb_flit_fifo.sv
// Bench for flit_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_flit_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [2:0]    flit_id;
    logic          empty, full, pkt_avail, ovf, udf;
    logic [PW:0]   count;

    flit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .flit_id(flit_id), .empty(empty), .full(full),
        .count(count), .pkt_avail(pkt_avail), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: the stored flits in order plus the two sticky flags.
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_tails();
        int n = 0;
        foreach (q[i]) if (q[i][DW-1:DW-3] == 3'b100) n++;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit wa, ra;
            wa = wr_en && (q.size() < DEPTH || rd_en);
            ra = rd_en && q.size() > 0;
            if (rd_en && q.size() == 0) m_udf = 1'b1;
            if (wr_en && q.size() == DEPTH && !rd_en) m_ovf = 1'b1;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(din);
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("count", DW'(count), DW'(n));
        chk("empty", DW'(empty), DW'(n == 0));
        chk("full", DW'(full), DW'(n == DEPTH));
        chk("pkt_avail", DW'(pkt_avail), DW'(m_tails() != 0));
        chk("ovf", DW'(ovf), DW'(m_ovf));
        chk("udf", DW'(udf), DW'(m_udf));
        chk("flit_id", DW'(flit_id), (n != 0) ? DW'(q[0][DW-1:DW-3]) : '0);
        if (n != 0) chk("dout", dout, q[0]);
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_flit();
        logic [2:0] t;
        case ($urandom_range(0, 4))
            0:       t = 3'b001;
            1, 2:    t = 3'b010;
            3:       t = 3'b100;
            default: t = 3'($urandom);
        endcase
        return {t, 29'($urandom)};
    endfunction

    logic [DW-1:0] exp_list [4];

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_count", DW'(count), '0);
        chk("rst_empty", DW'(empty), 1);
        chk("rst_flit_id", DW'(flit_id), '0);
        chk("rst_pkt", DW'(pkt_avail), '0);
        #10 rst = 1'b1;

        // Header, payload, tail.
        step(1, 32'h2000_0001, 0);
        step(1, 32'h4000_0002, 0);
        step(1, 32'h8000_0003, 0);
        chk("pkt_count", DW'(count), 3);
        chk("pkt_avail", DW'(pkt_avail), 1);
        chk("pkt_flit_id", DW'(flit_id), 3'b001);
        chk("pkt_dout", dout, 32'h2000_0001);

        // Fill, then overflow attempt.
        step(1, 32'h4000_0004, 0);
        step(1, 32'h8000_0005, 0);
        chk("ovf_full", DW'(full), 1);
        chk("ovf_flag", DW'(ovf), 1);
        chk("ovf_count", DW'(count), 4);
        exp_list = '{32'h2000_0001, 32'h4000_0002, 32'h8000_0003, 32'h4000_0004};
        for (int i = 0; i < 4; i++) begin
            chk("drain_dout", dout, exp_list[i]);
            step(0, '0, 1);
        end
        chk("drain_empty", DW'(empty), 1);
        chk("drain_udf", DW'(udf), 0);

        // Simultaneous read and write on empty: only the write lands.
        step(1, 32'h8000_00AA, 1);
        chk("udf_flag", DW'(udf), 1);
        chk("udf_count", DW'(count), 1);
        chk("udf_flit_id", DW'(flit_id), 3'b100);
        chk("udf_pkt", DW'(pkt_avail), 1);

        // Full with concurrent read/write for 8 cycles: pointers wrap twice.
        for (int i = 0; i < 3; i++) step(1, 32'h4000_0100 + DW'(i), 0);
        for (int i = 0; i < 8; i++) step(1, 32'h4000_0200 + DW'(i), 1);
        chk("wrap_count", DW'(count), 4);
        chk("wrap_full", DW'(full), 1);
        chk("wrap_dout", dout, 32'h4000_0204);

        // Asynchronous reset between edges with flits stored.
        step(0, '0, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", DW'(count), 0);
        chk("arst_empty", DW'(empty), 1);
        chk("arst_full", DW'(full), 0);
        chk("arst_pkt", DW'(pkt_avail), 0);
        chk("arst_ovf", DW'(ovf), 0);
        chk("arst_udf", DW'(udf), 0);
        chk("arst_flit_id", DW'(flit_id), 0);
        #3 rst = 1'b1;

        // Two packets: availability holds until the second tail leaves.
        step(1, 32'h2000_0010, 0);
        step(1, 32'h8000_0011, 0);
        step(1, 32'h2000_0020, 0);
        step(1, 32'h8000_0021, 0);
        chk("two_first", dout, 32'h2000_0010);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("two_mid_pkt", DW'(pkt_avail), 1);
        step(0, '0, 1);
        chk("two_last_pkt", DW'(pkt_avail), 1);
        step(0, '0, 1);
        chk("two_done_pkt", DW'(pkt_avail), 0);

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2 rst = 1'b0;
                #4 rst = 1'b1;
                @(posedge clk);
                #1;
            end
            step(1'($urandom_range(0, 99) < 55), rand_flit(), 1'($urandom_range(0, 99) < 45));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
